// File: rtl/accum_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accum_arbiter_pkg
//  Description : Shared state encoding and default parameter values for the
//                round-robin accumulator arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package accum_arbiter_pkg;

    localparam int c_DEF_NREQ    = 4;
    localparam int c_DEF_WIDTH   = 25;
    localparam int c_DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/accum_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin grant. The search begins one slot after the
//                pointer and wraps, so the last winner has lowest priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import accum_arbiter_pkg::*;
#(
    parameter int  NREQ = c_DEF_NREQ,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    int            w_pos;
    logic [IW-1:0] w_idx;
    logic          w_found;

    // Walk ptr+1, ptr+2, ... modulo NREQ and grant the first active request
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            w_idx = IW'(w_pos);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/accum_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : accum_arbiter
//  Description : Arbitrates NREQ add requests onto a shared accumulator
//                engine, returns the running sum per request and recovers
//                from an unresponsive engine with a bounded wait.
//  Revision    : 1.0 - initial release
// ============================================================================
module accum_arbiter
    import accum_arbiter_pkg::*;
#(
    parameter int NREQ    = c_DEF_NREQ,
    parameter int WIDTH   = c_DEF_WIDTH,
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset_l,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_add,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     acc_en,
    output logic [WIDTH-1:0]         acc_add,
    input  logic [WIDTH-1:0]         acc_accum,
    input  logic                     acc_done
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_id;
    logic [WIDTH-1:0] r_add;
    logic [CW-1:0]    r_cnt;
    logic [NREQ-1:0]  w_grant;
    logic [IW-1:0]    w_gnt_idx;
    logic [WIDTH-1:0] w_gnt_add;
    logic             w_fire;
    logic             w_err;
    logic             w_tmo;

    rr_arbiter #(
        .NREQ  (NREQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant)
    );

    // The wait limit fires on the cycle whose next count would reach
    // TIMEOUT, so the error response lands exactly TIMEOUT cycles after entry
    assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

    // Decode the one-hot grant into an index and the matching addend slice
    always_comb begin
        w_gnt_idx = '0;
        w_gnt_add = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_idx = IW'(i);
                w_gnt_add = req_add[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, response trigger and engine/handshake outputs
    always_comb begin
        w_next    = r_state;
        w_fire    = 1'b0;
        w_err     = 1'b0;
        req_ready = '0;
        acc_en    = 1'b0;
        acc_add   = '0;
        busy      = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                // reset_l gate keeps req_ready quiet while reset is held
                if (reset_l) begin
                    req_ready = w_grant;
                end
                if (|req_valid) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                acc_en  = 1'b1;
                acc_add = r_add;
                if (acc_done) begin
                    w_next = DRAIN;
                    w_fire = 1'b1;
                end else if (w_tmo) begin
                    w_next = DRAIN;
                    w_fire = 1'b1;
                    w_err  = 1'b1;
                end
            end
            DRAIN: begin
                if (!acc_done || w_tmo) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Grant bookkeeping, wait counter and registered response
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_ptr     <= IW'(NREQ - 1);
            r_id      <= '0;
            r_add     <= '0;
            r_cnt     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= w_fire;
            if (w_fire) begin
                rsp_id  <= r_id;
                rsp_sum <= w_err ? '0 : acc_accum;
                rsp_err <= w_err;
            end
            if (r_state != w_next) begin
                r_cnt <= '0;
            end else if (r_state != IDLE) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == IDLE && (|req_valid)) begin
                r_id  <= w_gnt_idx;
                r_add <= w_gnt_add;
                r_ptr <= w_gnt_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accum_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accum_arbiter
//  Description : Self-checking bench: directed scenarios plus random traffic,
//                compared cycle by cycle against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 25;
    localparam int T    = 15;
    localparam int M_NORM   = 0;
    localparam int M_STALL  = 1;
    localparam int M_STICKY = 2;

    logic              clk;
    logic              reset_l;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_add;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_err;
    logic              busy;
    logic              acc_en;
    logic [W-1:0]      acc_add;
    logic [W-1:0]      acc_accum;
    logic              acc_done;

    accum_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(T)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .req_valid (req_valid),
        .req_add   (req_add),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .acc_en    (acc_en),
        .acc_add   (acc_add),
        .acc_accum (acc_accum),
        .acc_done  (acc_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Engine model: done follows acc_en by one cycle; adds once per operation
    int           mode = M_NORM;
    logic         pre_req = 1'b0;
    logic [W-1:0] pre_val = '0;
    logic [W-1:0] eng_acc;
    logic         eng_done;
    assign acc_accum = eng_acc;
    assign acc_done  = eng_done;

    always @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            eng_done <= 1'b0;
        end else begin
            if (pre_req)
                eng_acc <= pre_val;
            else if (acc_en && !eng_done && mode != M_STALL)
                eng_acc <= eng_acc + acc_add;
            case (mode)
                M_STALL:  eng_done <= 1'b0;
                M_STICKY: eng_done <= acc_en | eng_done;
                default:  eng_done <= acc_en;
            endcase
        end
    end

    // Reference model state (transaction level)
    int           cyc = 0;
    int           free_c = 0;
    int           en_lo = 1, en_hi = 0, busy_lo = 1, busy_hi = 0;
    int           rsp_c = -1;
    int           e_id = 0;
    logic [W-1:0] e_sum = '0, e_add = '0;
    logic         e_err = 1'b0;
    int           mptr = NREQ - 1;
    logic [W-1:0] macc = '0;
    int           q_gnt[$];
    logic [W-1:0] q_sum[$];
    logic         q_err[$];

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Cycle monitor: predicts grants, engine drive, busy and responses
    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] exp_rdy;
        cyc++;
        if (!reset_l) begin
            check_val("rst_req_ready", req_ready, 0);
            check_val("rst_rsp_valid", rsp_valid, 0);
            check_val("rst_busy", busy, 0);
            check_val("rst_acc_en", acc_en, 0);
            check_val("rst_rsp_sum", rsp_sum, 0);
            mptr = NREQ - 1; free_c = 0; rsp_c = -1;
            en_lo = 1; en_hi = 0; busy_lo = 1; busy_hi = 0;
        end else begin
            if (cyc >= free_c) begin
                g = rr_pick(req_valid, mptr);
                exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
                check_val("req_ready", req_ready, exp_rdy);
                if (g >= 0) begin
                    mptr = g; e_id = g; e_add = req_add[g*W +: W];
                    en_lo = cyc + 1; busy_lo = cyc + 1;
                    if (mode == M_STALL) begin
                        rsp_c = cyc + 1 + T; e_err = 1'b1; e_sum = '0;
                        en_hi = cyc + T; free_c = cyc + T + 2;
                    end else begin
                        macc = macc + e_add;
                        rsp_c = cyc + 3; e_err = 1'b0; e_sum = macc;
                        en_hi = cyc + 2;
                        free_c = (mode == M_STICKY) ? cyc + 3 + T : cyc + 5;
                    end
                    busy_hi = free_c - 1;
                end
            end else begin
                check_val("req_ready_busy", req_ready, 0);
            end
            check_val("acc_en", acc_en, (cyc >= en_lo && cyc <= en_hi));
            if (cyc >= en_lo && cyc <= en_hi) check_val("acc_add", acc_add, e_add);
            check_val("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
            if (cyc == rsp_c) begin
                check_val("rsp_valid", rsp_valid, 1);
                check_val("rsp_id", rsp_id, e_id);
                check_val("rsp_sum", rsp_sum, e_sum);
                check_val("rsp_err", rsp_err, e_err);
            end else begin
                check_val("rsp_idle", rsp_valid, 0);
            end
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) q_gnt.push_back(i);
            if (rsp_valid) begin
                q_sum.push_back(rsp_sum);
                q_err.push_back(rsp_err);
            end
        end
    end

    // Stimulus helpers
    logic [NREQ-1:0]   rdy;
    logic [NREQ-1:0]   v;
    logic [NREQ*W-1:0] a;

    task automatic tick();
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk);
        #1;
        pre_req = 1'b0;
    endtask

    task automatic preload(input logic [W-1:0] val);
        pre_val = val;
        pre_req = 1'b1;
        macc    = val;
    endtask

    task automatic drive();
        req_valid = v;
        req_add   = a;
    endtask

    task automatic wait_accept(output logic [NREQ-1:0] got);
        got = '0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (|rdy) begin
                got = rdy;
                break;
            end
        end
        check_val("accept_wait", |got, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            tick();
            if (!busy) break;
        end
        check_val("idle_wait", busy, 0);
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        tick();
        tick();
        reset_l = 1'b1;
        preload('0);
    endtask

    task automatic clear_logs();
        q_gnt.delete();
        q_sum.delete();
        q_err.delete();
    endtask

    initial begin
        logic [NREQ-1:0] got;
        int ngr;
        reset_l = 1'b0; v = '0; a = '0; drive();
        repeat (3) tick();
        reset_l = 1'b1;
        preload('0);

        // Single request from requester 2
        clear_logs();
        v = 4'b0100; a[2*W +: W] = 25'd5; drive();
        wait_accept(got); v = '0; drive();
        wait_idle();
        check_val("single_gnt", got, 4'b0100);
        check_val("single_n", q_sum.size(), 1);
        if (q_sum.size() >= 1) check_val("single_sum", q_sum[0], 5);

        // Fairness: all four held, add 1 each, five grants
        do_reset(); clear_logs();
        v = 4'b1111;
        for (int i = 0; i < NREQ; i++) a[i*W +: W] = 25'd1;
        drive();
        ngr = 0;
        for (int k = 0; k < 100 && ngr < 5; k++) begin
            tick();
            ngr += $countones(rdy);
        end
        v = '0; drive();
        wait_idle();
        check_val("fair_n", q_sum.size(), 5);
        for (int k = 0; k < 5 && k < q_sum.size() && k < q_gnt.size(); k++) begin
            check_val("fair_gnt", q_gnt[k], k % NREQ);
            check_val("fair_sum", q_sum[k], k + 1);
        end

        // Wrap modulo 2^W
        clear_logs(); preload(25'h1FFFFFF);
        v = 4'b0001; a[0 +: W] = 25'd1; drive();
        wait_accept(got); v = '0; drive();
        wait_idle();
        if (q_sum.size() >= 1) begin
            check_val("wrap_sum", q_sum[0], 0);
            check_val("wrap_err", q_err[0], 0);
        end else check_val("wrap_n", q_sum.size(), 1);

        // Engine never completes: error response after TIMEOUT cycles
        clear_logs(); mode = M_STALL;
        v = 4'b1000; a[3*W +: W] = 25'd7; drive();
        wait_accept(got); v = '0; drive();
        wait_idle();
        mode = M_NORM; tick(); tick();
        if (q_sum.size() >= 1) begin
            check_val("tmo_err", q_err[0], 1);
            check_val("tmo_sum", q_sum[0], 0);
        end else check_val("tmo_n", q_sum.size(), 1);

        // Engine never drops done: DRAIN leaves on its own limit
        clear_logs(); mode = M_STICKY;
        v = 4'b0010; a[1*W +: W] = 25'd2; drive();
        wait_accept(got); v = '0; drive();
        wait_idle();
        mode = M_NORM; tick(); tick();
        check_val("sticky_n", q_sum.size(), 1);

        // Request 1 withdrawn while requester 0 is being served
        do_reset(); clear_logs();
        v = 4'b0011; a[0 +: W] = 25'd3; a[W +: W] = 25'd4; drive();
        wait_accept(got);
        v = '0; drive();
        wait_idle(); tick();
        check_val("drop_gnt", got, 4'b0001);
        check_val("drop_ngnt", q_gnt.size(), 1);
        if (q_sum.size() >= 1) check_val("drop_sum", q_sum[0], 3);

        // Reset while the engine is being driven
        clear_logs();
        v = 4'b1010; a[W +: W] = 25'd9; a[3*W +: W] = 25'd11; drive();
        wait_accept(got);
        check_val("pre_rst_en", acc_en, 1);
        #2 reset_l = 1'b0;
        #1;
        check_val("arst_acc_en", acc_en, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_ready", req_ready, 0);
        check_val("arst_rsp", rsp_valid, 0);
        check_val("arst_add", acc_add, 0);
        tick(); tick();
        reset_l = 1'b1; preload('0); clear_logs();
        wait_accept(got);
        v = '0; drive();
        check_val("post_rst_gnt", got, 4'b0010);
        wait_idle();

        // Random traffic with occasional withdrawals while busy
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (v[i] && rdy[i]) v[i] = 1'b0;
                else if (v[i] && busy && $urandom_range(15) == 0) v[i] = 1'b0;
                else if (!v[i] && $urandom_range(3) == 0) begin
                    v[i] = 1'b1;
                    a[i*W +: W] = W'($urandom);
                end
            end
            drive();
            tick();
        end
        v = '0; drive();
        wait_idle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
